// File: rtl/sne_neuron_pkg.sv
// rtl/sne_neuron_pkg.sv - shared encodings for the neuron event sequencer
// Contents: spike_op encoding, input event types, sequencer FSM states.
package sne_neuron_pkg;

    // Neuron operation codes; 4..7 are reserved.
    localparam logic [2:0] OP_NOP       = 3'd0;
    localparam logic [2:0] OP_INTEGRATE = 3'd1;
    localparam logic [2:0] OP_UPDATE    = 3'd2;
    localparam logic [2:0] OP_RESET     = 3'd3;

    typedef enum logic [1:0] {
        EVT_SPIKE = 2'd0,
        EVT_TIME  = 2'd1,
        EVT_RESET = 2'd2,
        EVT_RSVD  = 2'd3
    } evt_type_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } seq_state_e;

endpackage

// File: rtl/neuron_weight_table.sv
// rtl/neuron_weight_table.sv - synaptic weight register file
// Ports: clk_i/rst_ni clock and async active-low reset (clears all entries);
//        we_i/waddr_i/wdata_i write port; raddr_i/rdata_o combinational read.
// Reads of addresses >= NUM_SYN return 0; writes to them are ignored.
module neuron_weight_table #(
    parameter int NUM_SYN          = 64,
    parameter int SRC_WIDTH        = $clog2(NUM_SYN),
    parameter int SYN_WEIGHT_WIDTH = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        we_i,
    input  logic [SRC_WIDTH-1:0]        waddr_i,
    input  logic [SYN_WEIGHT_WIDTH-1:0] wdata_i,
    input  logic [SRC_WIDTH-1:0]        raddr_i,
    output logic [SYN_WEIGHT_WIDTH-1:0] rdata_o
);

    logic [SYN_WEIGHT_WIDTH-1:0] mem_q [NUM_SYN];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
        end else if (we_i && (int'(waddr_i) < NUM_SYN)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read sees the pre-write contents when a write hits the same address.
    always_comb begin
        rdata_o = '0;
        if (int'(raddr_i) < NUM_SYN) begin
            rdata_o = mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/neuron_event_sequencer.sv
// rtl/neuron_event_sequencer.sv - event front end of the ALIF neuron wrapper
// Ports: clk_i/rst_ni clock and async active-low reset; enable_i, stall_i control;
//        evt_* input event stream (valid/ready); cfg_* weight-table write and scale;
//        clr_i clears error and counter; spike_op_o/spike_o/time_o/syn_weight_o/
//        syn_weight_scale_o registered neuron inputs; spike_cnt_o, err_o status.
module neuron_event_sequencer
    import sne_neuron_pkg::*;
#(
    parameter int NUM_SYN          = 64,
    parameter int SRC_WIDTH        = $clog2(NUM_SYN),
    parameter int SYN_WEIGHT_WIDTH = 4,
    parameter int TIME_WIDTH       = 8,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        enable_i,
    input  logic                        stall_i,
    input  logic                        evt_valid_i,
    output logic                        evt_ready_o,
    input  logic [1:0]                  evt_type_i,
    input  logic [SRC_WIDTH-1:0]        evt_src_i,
    input  logic [TIME_WIDTH-1:0]       evt_time_i,
    input  logic                        cfg_we_i,
    input  logic [SRC_WIDTH-1:0]        cfg_addr_i,
    input  logic [SYN_WEIGHT_WIDTH-1:0] cfg_wdata_i,
    input  logic [SYN_WEIGHT_WIDTH-1:0] cfg_scale_i,
    input  logic                        clr_i,
    output logic [2:0]                  spike_op_o,
    output logic                        spike_o,
    output logic [TIME_WIDTH-1:0]       time_o,
    output logic [SYN_WEIGHT_WIDTH-1:0] syn_weight_o,
    output logic [SYN_WEIGHT_WIDTH-1:0] syn_weight_scale_o,
    output logic [CNT_WIDTH-1:0]        spike_cnt_o,
    output logic                        err_o
);

    seq_state_e state_q, state_d;
    logic       evt_accept;
    logic       hold_outputs;

    logic [SYN_WEIGHT_WIDTH-1:0] rd_weight;
    logic [2:0]                  op_d;
    logic                        spike_d;
    logic [TIME_WIDTH-1:0]       time_d;
    logic [SYN_WEIGHT_WIDTH-1:0] weight_d;
    logic [CNT_WIDTH-1:0]        cnt_d;
    logic                        err_d;
    logic                        cnt_inc;
    logic                        err_set;

    neuron_weight_table #(
        .NUM_SYN          (NUM_SYN),
        .SRC_WIDTH        (SRC_WIDTH),
        .SYN_WEIGHT_WIDTH (SYN_WEIGHT_WIDTH)
    ) u_weight_table (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .we_i    (cfg_we_i),
        .waddr_i (cfg_addr_i),
        .wdata_i (cfg_wdata_i),
        .raddr_i (evt_src_i),
        .rdata_o (rd_weight)
    );

    // FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. A stall takes priority over a dropped enable; the
    // enable is re-examined once the stall clears.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: state_d = enable_i ? ST_RUN : ST_IDLE;
            ST_RUN:  state_d = stall_i ? ST_HOLD : (enable_i ? ST_RUN : ST_IDLE);
            ST_HOLD: state_d = stall_i ? ST_HOLD : (enable_i ? ST_RUN : ST_IDLE);
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        evt_ready_o  = (state_q == ST_RUN) && !stall_i;
        hold_outputs = (state_q == ST_HOLD);
        evt_accept   = evt_valid_i && evt_ready_o;
    end

    // Event decode into next-cycle output values.
    always_comb begin
        op_d     = OP_NOP;
        spike_d  = 1'b0;
        time_d   = time_o;
        weight_d = syn_weight_o;
        cnt_inc  = 1'b0;
        err_set  = 1'b0;
        if (evt_accept) begin
            case (evt_type_e'(evt_type_i))
                EVT_SPIKE: begin
                    op_d     = OP_INTEGRATE;
                    spike_d  = 1'b1;
                    weight_d = rd_weight;
                    cnt_inc  = 1'b1;
                end
                EVT_TIME: begin
                    if (evt_time_i > time_o) begin
                        op_d   = OP_UPDATE;
                        time_d = evt_time_i;
                    end else if (evt_time_i < time_o) begin
                        err_set = 1'b1;
                    end
                end
                EVT_RESET: begin
                    op_d   = OP_RESET;
                    time_d = '0;
                end
                default: ;
            endcase
        end
        // clr_i acts first so a same-cycle spike or error still lands.
        cnt_d = clr_i ? '0 : spike_cnt_o;
        if (cnt_inc && (cnt_d != '1)) begin
            cnt_d = cnt_d + 1'b1;
        end
        err_d = err_set || (err_o && !clr_i);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spike_op_o         <= OP_NOP;
            spike_o            <= 1'b0;
            time_o             <= '0;
            syn_weight_o       <= '0;
            syn_weight_scale_o <= '0;
            spike_cnt_o        <= '0;
            err_o              <= 1'b0;
        end else if (!hold_outputs) begin
            spike_op_o         <= op_d;
            spike_o            <= spike_d;
            time_o             <= time_d;
            syn_weight_o       <= weight_d;
            syn_weight_scale_o <= cfg_scale_i;
            spike_cnt_o        <= cnt_d;
            err_o              <= err_d;
        end
    end

endmodule

// File: tb/tb_neuron_event_sequencer.sv
// tb/tb_neuron_event_sequencer.sv - directed self-checking bench for neuron_event_sequencer
`timescale 1ns/1ps
module tb_neuron_event_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        enable_i;
    logic        stall_i;
    logic        evt_valid_i;
    logic        evt_ready_o;
    logic [1:0]  evt_type_i;
    logic [5:0]  evt_src_i;
    logic [7:0]  evt_time_i;
    logic        cfg_we_i;
    logic [5:0]  cfg_addr_i;
    logic [3:0]  cfg_wdata_i;
    logic [3:0]  cfg_scale_i;
    logic        clr_i;
    logic [2:0]  spike_op_o;
    logic        spike_o;
    logic [7:0]  time_o;
    logic [3:0]  syn_weight_o;
    logic [3:0]  syn_weight_scale_o;
    logic [15:0] spike_cnt_o;
    logic        err_o;

    int n_checks = 0;
    int n_pass   = 0;

    neuron_event_sequencer dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .enable_i           (enable_i),
        .stall_i            (stall_i),
        .evt_valid_i        (evt_valid_i),
        .evt_ready_o        (evt_ready_o),
        .evt_type_i         (evt_type_i),
        .evt_src_i          (evt_src_i),
        .evt_time_i         (evt_time_i),
        .cfg_we_i           (cfg_we_i),
        .cfg_addr_i         (cfg_addr_i),
        .cfg_wdata_i        (cfg_wdata_i),
        .cfg_scale_i        (cfg_scale_i),
        .clr_i              (clr_i),
        .spike_op_o         (spike_op_o),
        .spike_o            (spike_o),
        .time_o             (time_o),
        .syn_weight_o       (syn_weight_o),
        .syn_weight_scale_o (syn_weight_scale_o),
        .spike_cnt_o        (spike_cnt_o),
        .err_o              (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // One-cycle event presentation; assumes the sequencer is ready.
    task automatic send(input logic [1:0] t, input logic [5:0] s, input logic [7:0] tm);
        evt_valid_i = 1'b1;
        evt_type_i  = t;
        evt_src_i   = s;
        evt_time_i  = tm;
        tick();
        evt_valid_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [5:0] a, input logic [3:0] d);
        cfg_we_i    = 1'b1;
        cfg_addr_i  = a;
        cfg_wdata_i = d;
        tick();
        cfg_we_i    = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_ni = 1'b0; enable_i = 1'b0; stall_i = 1'b0; evt_valid_i = 1'b0;
        evt_type_i = 2'd0; evt_src_i = '0; evt_time_i = '0;
        cfg_we_i = 1'b0; cfg_addr_i = '0; cfg_wdata_i = '0; cfg_scale_i = 4'h3; clr_i = 1'b0;
        tick(); tick();
        chk("rst_op", 32'(spike_op_o), 32'd0);
        chk("rst_spike", 32'(spike_o), 32'd0);
        chk("rst_time", 32'(time_o), 32'd0);
        chk("rst_weight", 32'(syn_weight_o), 32'd0);
        chk("rst_scale", 32'(syn_weight_scale_o), 32'd0);
        chk("rst_cnt", 32'(spike_cnt_o), 32'd0);
        chk("rst_err", 32'(err_o), 32'd0);
        chk("rst_ready", 32'(evt_ready_o), 32'd0);

        rst_ni = 1'b1;
        tick();
        chk("idle_ready", 32'(evt_ready_o), 32'd0);
        enable_i = 1'b1;
        tick();
        chk("run_ready", 32'(evt_ready_o), 32'd1);
        chk("scale_reg", 32'(syn_weight_scale_o), 32'h3);

        cfg_write(6'd5, 4'hD);
        cfg_write(6'd2, 4'h1);
        send(2'd0, 6'd5, 8'd0);
        chk("spk_op", 32'(spike_op_o), 32'd1);
        chk("spk_spike", 32'(spike_o), 32'd1);
        chk("spk_weight", 32'(syn_weight_o), 32'hD);
        chk("spk_cnt", 32'(spike_cnt_o), 32'd1);
        tick();
        chk("nop_op", 32'(spike_op_o), 32'd0);
        chk("nop_spike", 32'(spike_o), 32'd0);
        chk("nop_weight_hold", 32'(syn_weight_o), 32'hD);

        send(2'd1, 6'd0, 8'd10);
        chk("t10_op", 32'(spike_op_o), 32'd2);
        chk("t10_time", 32'(time_o), 32'd10);
        send(2'd1, 6'd0, 8'd10);
        chk("teq_op", 32'(spike_op_o), 32'd0);
        chk("teq_err", 32'(err_o), 32'd0);
        send(2'd1, 6'd0, 8'd7);
        chk("tback_op", 32'(spike_op_o), 32'd0);
        chk("tback_err", 32'(err_o), 32'd1);
        chk("tback_time", 32'(time_o), 32'd10);
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        chk("clr_err", 32'(err_o), 32'd0);
        chk("clr_cnt", 32'(spike_cnt_o), 32'd0);

        // Stall with a pending spike.
        stall_i = 1'b1; evt_valid_i = 1'b1; evt_type_i = 2'd0; evt_src_i = 6'd5;
        #1;
        chk("stall_ready_run", 32'(evt_ready_o), 32'd0);
        tick();
        cfg_scale_i = 4'h9;
        tick(); tick();
        chk("hold_ready", 32'(evt_ready_o), 32'd0);
        chk("hold_cnt", 32'(spike_cnt_o), 32'd0);
        chk("hold_spike", 32'(spike_o), 32'd0);
        chk("hold_scale", 32'(syn_weight_scale_o), 32'h3);
        stall_i = 1'b0;
        tick();
        chk("rel_ready", 32'(evt_ready_o), 32'd1);
        chk("rel_cnt", 32'(spike_cnt_o), 32'd0);
        tick();
        evt_valid_i = 1'b0;
        chk("rel_spike", 32'(spike_o), 32'd1);
        chk("rel_cnt1", 32'(spike_cnt_o), 32'd1);
        chk("rel_scale", 32'(syn_weight_scale_o), 32'h9);

        // Same-cycle write and lookup return the old weight.
        cfg_we_i = 1'b1; cfg_addr_i = 6'd2; cfg_wdata_i = 4'h7;
        send(2'd0, 6'd2, 8'd0);
        cfg_we_i = 1'b0;
        chk("wr_same_old", 32'(syn_weight_o), 32'h1);
        send(2'd0, 6'd2, 8'd0);
        chk("wr_new", 32'(syn_weight_o), 32'h7);
        chk("cnt3", 32'(spike_cnt_o), 32'd3);

        // clr with a spike gives 1, then run the counter into saturation.
        clr_i = 1'b1;
        send(2'd0, 6'd5, 8'd0);
        clr_i = 1'b0;
        chk("clr_spike_cnt", 32'(spike_cnt_o), 32'd1);
        evt_valid_i = 1'b1;
        repeat (65533) tick();
        chk("cnt_fffe", 32'(spike_cnt_o), 32'hFFFE);
        tick();
        chk("cnt_ffff", 32'(spike_cnt_o), 32'hFFFF);
        tick(); tick();
        evt_valid_i = 1'b0;
        chk("cnt_sat", 32'(spike_cnt_o), 32'hFFFF);

        // Backward time together with clr: set wins.
        clr_i = 1'b1;
        send(2'd1, 6'd0, 8'd5);
        clr_i = 1'b0;
        chk("clr_vs_set_err", 32'(err_o), 32'd1);
        chk("clr_vs_set_cnt", 32'(spike_cnt_o), 32'd0);
        clr_i = 1'b1; tick(); clr_i = 1'b0;
        send(2'd0, 6'd5, 8'd0);

        send(2'd2, 6'd0, 8'd0);
        chk("rstevt_op", 32'(spike_op_o), 32'd3);
        chk("rstevt_time", 32'(time_o), 32'd0);
        chk("rstevt_cnt", 32'(spike_cnt_o), 32'd1);
        send(2'd1, 6'd0, 8'd3);
        chk("t3_op", 32'(spike_op_o), 32'd2);
        chk("t3_time", 32'(time_o), 32'd3);
        chk("t3_err", 32'(err_o), 32'd0);
        send(2'd3, 6'd2, 8'd9);
        chk("rsvd_op", 32'(spike_op_o), 32'd0);
        chk("rsvd_time", 32'(time_o), 32'd3);
        chk("rsvd_weight", 32'(syn_weight_o), 32'hD);

        // Enable drop with a same-cycle event: event still processed.
        enable_i = 1'b0;
        send(2'd0, 6'd2, 8'd0);
        chk("endrop_spike", 32'(spike_o), 32'd1);
        chk("endrop_cnt", 32'(spike_cnt_o), 32'd2);
        chk("endrop_ready", 32'(evt_ready_o), 32'd0);
        tick();
        chk("idle_op", 32'(spike_op_o), 32'd0);
        chk("idle_spike", 32'(spike_o), 32'd0);

        // Asynchronous reset mid-stream.
        enable_i = 1'b1;
        tick();
        send(2'd1, 6'd0, 8'd20);
        chk("t20_time", 32'(time_o), 32'd20);
        #3 rst_ni = 1'b0;
        #1;
        chk("arst_time", 32'(time_o), 32'd0);
        chk("arst_op", 32'(spike_op_o), 32'd0);
        chk("arst_cnt", 32'(spike_cnt_o), 32'd0);
        chk("arst_weight", 32'(syn_weight_o), 32'd0);
        chk("arst_scale", 32'(syn_weight_scale_o), 32'd0);
        rst_ni = 1'b1;
        tick(); tick();
        send(2'd0, 6'd2, 8'd0);
        chk("arst_table_clr", 32'(syn_weight_o), 32'd0);
        chk("arst_cnt1", 32'(spike_cnt_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
